// File: rtl/modadd_rr_sched.sv
// modadd_rr_sched: round-robin share of a two-stage modular adder; optional MODADD_RANGE_CHECK_EN adds out_err
module modadd_rr_sched #(
    parameter int DATA_WIDTH = 18,
    parameter int MODULUS    = 177147,
    parameter int NUM_REQ    = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_a,
    input  logic [NUM_REQ*(DATA_WIDTH-2)-1:0]   req_b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_result,
    output logic [ID_W-1:0]                     out_id,
    output logic                                busy
`ifdef MODADD_RANGE_CHECK_EN
    ,output logic                               out_err
`endif
);
    localparam logic [DATA_WIDTH:0] MOD_W = (DATA_WIDTH+1)'(MODULUS);
    logic [ID_W-1:0] rr_ptr, gnt_id, idx, s1_id, s2_id;
    logic found, stall, fire, s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0] a_sel, s2_result;
    logic [DATA_WIDTH-3:0] b_sel;
    logic [DATA_WIDTH:0] sum, s1_sum;
    logic [DATA_WIDTH+1:0] diff, s1_diff;
`ifdef MODADD_RANGE_CHECK_EN
    logic s1_err, s2_err;
`endif
    assign stall = s2_valid && !out_ready;
    assign fire = found && !stall && !reset;
    assign req_ready = fire ? NUM_REQ'(1) << gnt_id : '0;
    assign a_sel = req_a[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = req_b[gnt_id*(DATA_WIDTH-2) +: DATA_WIDTH-2];
    assign sum = {1'b0, a_sel} + (DATA_WIDTH+1)'(b_sel);
    assign diff = {1'b0, sum} - {1'b0, MOD_W};
    assign out_valid = s2_valid;
    assign out_result = s2_result;
    assign out_id = s2_id;
    assign busy = s1_valid || s2_valid;
`ifdef MODADD_RANGE_CHECK_EN
    assign out_err = s2_err;
`endif
    // pick the first valid requester after the last one served, wrapping around
    always_comb begin
        found = 1'b0;
        gnt_id = rr_ptr;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt_id = idx;
            end
        end
    end
    // two-stage add/reduce pipeline; the whole pipe freezes while the output is blocked
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= ID_W'(NUM_REQ-1);
            s1_valid <= 1'b0;
            s1_sum <= '0;
            s1_diff <= '0;
            s1_id <= '0;
            s2_valid <= 1'b0;
            s2_result <= '0;
            s2_id <= '0;
`ifdef MODADD_RANGE_CHECK_EN
            s1_err <= 1'b0;
            s2_err <= 1'b0;
`endif
        end else if (!stall) begin
            s1_valid <= fire;
            if (fire) begin
                rr_ptr <= gnt_id;
                s1_sum <= sum;
                s1_diff <= diff;
                s1_id <= gnt_id;
`ifdef MODADD_RANGE_CHECK_EN
                s1_err <= {1'b0, a_sel} >= MOD_W;
`endif
            end
            s2_valid <= s1_valid;
            s2_result <= s1_diff[DATA_WIDTH+1] ? s1_sum[DATA_WIDTH-1:0] : s1_diff[DATA_WIDTH-1:0];
            s2_id <= s1_id;
`ifdef MODADD_RANGE_CHECK_EN
            s2_err <= s1_err;
`endif
        end
    end
endmodule

// File: tb/tb_modadd_rr_sched.sv
// tb_modadd_rr_sched: directed self-checking bench for modadd_rr_sched
module tb_modadd_rr_sched;
    localparam int DW = 18;
    localparam int NR = 4;
    localparam int BW = DW - 2;
    logic clk, reset, out_ready, out_valid, busy;
    logic [NR-1:0] req_valid, req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic [DW-1:0] out_result;
    logic [1:0] out_id;
`ifdef MODADD_RANGE_CHECK_EN
    logic out_err;
`endif
    int tests, fails;

    modadd_rr_sched dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_id(out_id), .busy(busy)
`ifdef MODADD_RANGE_CHECK_EN
        , .out_err(out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int v, input int r, input int id);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v != 0) begin
            check({tag, "_result"}, 32'(out_result), 32'(r));
            check({tag, "_id"}, 32'(out_id), 32'(id));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        tick();
        set_op(0, 177146, 1);
        req_valid = 4'b0001;
        tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_result", 32'(out_result), 0);
        check("rst_id", 32'(out_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        // single op with wrap to zero
        reset = 1'b0;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("single_busy", 32'(busy), 1);
        check("single_s1_valid", 32'(out_valid), 0);
        tick();
        chk_out("single", 1, 0, 0);
        // requester 1: no reduction then reduction, back to back
        set_op(1, 100000, 50000);
        req_valid = 4'b0010;
        #1;
        check("red_ready0", 32'(req_ready), 32'h2);
        tick();
        set_op(1, 177000, 65535);
        #1;
        check("red_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk_out("nored", 1, 150000, 1);
        tick();
        chk_out("red", 1, 65388, 1);
        tick();
        chk_out("red_idle", 0, 0, 0);
        check("red_idle_busy", 32'(busy), 0);
        // round robin after fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_op(i, i*1000 + 1, i);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            check($sformatf("rr_ready_c%0d", c), 32'(req_ready), (c < 8) ? 32'(1 << (c % 4)) : 0);
            if (c >= 2) chk_out($sformatf("rr_out_c%0d", c), 1, ((c-2)%4)*1001 + 1, (c-2)%4);
            else chk_out($sformatf("rr_out_c%0d", c), 0, 0, 0);
            tick();
        end
        // backpressure: two ops on requester 2, then output blocked
        req_valid = 4'b0100;
        set_op(2, 5, 6);
        tick();
        set_op(2, 7, 8);
        tick();
        chk_out("bp_first", 1, 11, 2);
        out_ready = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 1, 1);
        #1;
        check("bp_ready_now", 32'(req_ready), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("bp_hold_c%0d", c), 1, 11, 2);
            check($sformatf("bp_ready_c%0d", c), 32'(req_ready), 0);
            check($sformatf("bp_busy_c%0d", c), 32'(busy), 1);
        end
        out_ready = 1'b1;
        req_valid = '0;
        tick();
        chk_out("bp_second", 1, 15, 2);
        tick();
        chk_out("bp_drained", 0, 0, 0);
        // reset while two ops are in flight
        req_valid = 4'b0010;
        set_op(1, 10, 10);
        tick();
        set_op(1, 20, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("mid_ready", 32'(req_ready), 32'h1);
        check("mid_busy0", 32'(busy), 0);
        check("mid_valid0", 32'(out_valid), 0);
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("mid_valid_c%0d", c), 32'(out_valid), 0);
            check($sformatf("mid_busy_c%0d", c), 32'(busy), 0);
        end
        // range boundary: A == MODULUS, then A == MODULUS-1
        req_valid = 4'b0001;
        set_op(0, 177147, 0);
        #1;
        check("rng_ready0", 32'(req_ready), 32'h1);
        tick();
        set_op(0, 177146, 0);
        #1;
        check("rng_ready1", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk_out("rng_over", 1, 0, 0);
`ifdef MODADD_RANGE_CHECK_EN
        check("rng_err1", 32'(out_err), 1);
`endif
        tick();
        chk_out("rng_max", 1, 177146, 0);
`ifdef MODADD_RANGE_CHECK_EN
        check("rng_err0", 32'(out_err), 0);
`endif
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
